// File: rtl/dma_loader.sv
// -----------------------------------------------------------------------------
// dma_loader
// Upstream DMA sequencer for the Neptune I control matrix. It takes a program
// image as a valid/ready word stream and writes it into RAM through the
// control matrix DMA port. The sequence is: load MAR with the base address,
// then for each word write RAM and pulse a MAR increment, then write PC with
// the entry address and release the processor.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   start               one-cycle load request, sampled only while idle
//   base_addr           first RAM address (latched on start)
//   entry_addr          PC value after the load (latched on start)
//   word_cnt            number of words to load (latched on start)
//   in_data/in_valid    upstream image stream
//   in_ready            loader accepts a stream word this cycle
//   dma_appr            DMA approval from the control matrix
//   dma_req, cm_rst     DMA request and control matrix reset (driven together)
//   we_out              write select: 000 none, 011 RAM, 100 PC, 101 MAR
//   mar_incr            MAR increment request
//   dma_data            data bus value for the current write
//   busy                high in every state except IDLE
//   done                one-cycle pulse when a load completes
//   err                 one-cycle pulse on approval timeout or lost approval
// -----------------------------------------------------------------------------
module dma_loader #(
  parameter int width        = 16,
  parameter int cnt_width    = 16,
  parameter int appr_timeout = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [width-1:0]     base_addr,
  input  logic [width-1:0]     entry_addr,
  input  logic [cnt_width-1:0] word_cnt,
  input  logic [width-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 dma_appr,
  output logic                 dma_req,
  output logic                 cm_rst,
  output logic [2:0]           we_out,
  output logic                 mar_incr,
  output logic [width-1:0]     dma_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int TMO_W = (appr_timeout > 1) ? $clog2(appr_timeout) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(appr_timeout - 1);
  localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_RAM  = 3'b011;
  localparam logic [2:0] WE_PC   = 3'b100;
  localparam logic [2:0] WE_MAR  = 3'b101;

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    SET_MAR,
    WAIT_DATA,
    WRITE,
    INCR,
    SET_PC,
    RELEASE,
    FAIL
  } state_t;

  state_t                 state;
  logic [width-1:0]       base_q;
  logic [width-1:0]       entry_q;
  logic [cnt_width-1:0]   cnt_q;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   appr_checked;

  // Once the matrix has granted DMA, approval must stay up until the PC write
  // is done. These are the states in which a dropped approval aborts the load.
  assign appr_checked = (state == SET_MAR) || (state == WAIT_DATA) ||
                        (state == WRITE)   || (state == INCR)      ||
                        (state == SET_PC);

  // Sequencer. Every output is a register loaded together with the state it
  // belongs to, so each branch below sets the outputs of the state it enters.
  // Pulse-type outputs default to 0 each cycle; dma_req/cm_rst/busy hold
  // their value until a transition changes them.
  // A lost approval wins over everything else, including a stream handshake
  // in WAIT_DATA; that word is then dropped along with the rest of the load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      base_q   <= '0;
      entry_q  <= '0;
      cnt_q    <= '0;
      tmo_cnt  <= '0;
      in_ready <= 1'b0;
      dma_req  <= 1'b0;
      cm_rst   <= 1'b0;
      we_out   <= WE_NONE;
      mar_incr <= 1'b0;
      dma_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      we_out   <= WE_NONE;
      mar_incr <= 1'b0;
      in_ready <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;

      if (appr_checked && !dma_appr) begin
        state    <= FAIL;
        dma_req  <= 1'b0;
        cm_rst   <= 1'b0;
        dma_data <= '0;
        err      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= REQ;
              base_q  <= base_addr;
              entry_q <= entry_addr;
              cnt_q   <= word_cnt;
              tmo_cnt <= '0;
              dma_req <= 1'b1;
              cm_rst  <= 1'b1;
              busy    <= 1'b1;
            end
          end

          REQ: begin
            if (dma_appr) begin
              state    <= SET_MAR;
              we_out   <= WE_MAR;
              dma_data <= base_q;
            end else if (tmo_cnt == TMO_LAST) begin
              state    <= FAIL;
              dma_req  <= 1'b0;
              cm_rst   <= 1'b0;
              dma_data <= '0;
              err      <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end

          SET_MAR: begin
            if (cnt_q != '0) begin
              state    <= WAIT_DATA;
              in_ready <= 1'b1;
            end else begin
              state    <= SET_PC;
              we_out   <= WE_PC;
              dma_data <= entry_q;
            end
          end

          WAIT_DATA: begin
            if (in_valid) begin
              state    <= WRITE;
              we_out   <= WE_RAM;
              dma_data <= in_data;
            end else begin
              in_ready <= 1'b1;
            end
          end

          WRITE: begin
            state    <= INCR;
            mar_incr <= 1'b1;
          end

          INCR: begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_ONE) begin
              state    <= SET_PC;
              we_out   <= WE_PC;
              dma_data <= entry_q;
            end else begin
              state    <= WAIT_DATA;
              in_ready <= 1'b1;
            end
          end

          SET_PC: begin
            state   <= RELEASE;
            dma_req <= 1'b0;
            cm_rst  <= 1'b0;
            done    <= 1'b1;
          end

          default: begin
            state   <= IDLE;
            dma_req <= 1'b0;
            cm_rst  <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
